// File: rtl/input_replay_buffer_pkg.sv
// rtl/input_replay_buffer_pkg.sv - shared types and helpers for the input replay buffer
package input_replay_buffer_pkg;

    typedef enum logic [0:0] {
        FILL   = 1'b0,
        REPLAY = 1'b1
    } irb_state_t;

    // Counter width that stays legal when the count range collapses to one value.
    function automatic int ctr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/input_replay_buffer.sv
// rtl/input_replay_buffer.sv - captures one input vector and replays it REPEAT times downstream
module input_replay_buffer
    import input_replay_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DATA_SIZE  = 4,
    parameter int DEPTH      = 3,
    parameter int REPEAT     = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in [DATA_SIZE],
    input  logic                  data_in_valid,
    output logic                  data_in_ready,
    output logic [DATA_WIDTH-1:0] data_out [DATA_SIZE],
    output logic                  data_out_valid,
    input  logic                  data_out_ready,
    output logic                  data_out_last
);

    localparam int PTR_W  = ctr_width(DEPTH);
    localparam int PASS_W = ctr_width(REPEAT);
    localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(DEPTH - 1);
    localparam logic [PASS_W-1:0] PASS_LAST = PASS_W'(REPEAT - 1);

    irb_state_t              state, state_nxt;
    logic [PTR_W-1:0]        ptr, ptr_nxt;
    logic [PASS_W-1:0]       pass, pass_nxt;
    logic [DATA_WIDTH-1:0]   store [DEPTH][DATA_SIZE];
    logic                    load;
    logic                    fill_hs;
    logic                    out_load;
    logic                    out_from_store;
    logic                    valid_nxt;

    always_comb begin
        load           = !data_out_valid || data_out_ready;
        state_nxt      = state;
        ptr_nxt        = ptr;
        pass_nxt       = pass;
        data_in_ready  = 1'b0;
        fill_hs        = 1'b0;
        out_load       = 1'b0;
        out_from_store = 1'b0;
        valid_nxt      = data_out_valid;

        case (state)
            FILL: begin
                data_in_ready = load;
                fill_hs       = data_in_valid && load;
                if (fill_hs) begin
                    out_load  = 1'b1;
                    valid_nxt = 1'b1;
                    if (ptr == PTR_LAST) begin
                        ptr_nxt = '0;
                        if (REPEAT > 1) begin
                            state_nxt = REPLAY;
                            pass_nxt  = PASS_W'(1);
                        end
                    end else begin
                        ptr_nxt = ptr + PTR_W'(1);
                    end
                end else if (load) begin
                    valid_nxt = 1'b0;
                end
            end
            REPLAY: begin
                if (load) begin
                    out_load       = 1'b1;
                    out_from_store = 1'b1;
                    valid_nxt      = 1'b1;
                    if (ptr == PTR_LAST) begin
                        ptr_nxt = '0;
                        // Returning to FILL here lets the next vector in on the following cycle.
                        if (pass == PASS_LAST) begin
                            state_nxt = FILL;
                            pass_nxt  = '0;
                        end else begin
                            pass_nxt = pass + PASS_W'(1);
                        end
                    end else begin
                        ptr_nxt = ptr + PTR_W'(1);
                    end
                end
            end
            default: state_nxt = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= FILL;
            ptr   <= '0;
            pass  <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            pass  <= pass_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_hs) begin
            for (int i = 0; i < DATA_SIZE; i++) begin
                store[ptr][i] <= data_in[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DATA_SIZE; i++) begin
                data_out[i] <= '0;
            end
            data_out_valid <= 1'b0;
            data_out_last  <= 1'b0;
        end else begin
            data_out_valid <= valid_nxt;
            if (out_load) begin
                for (int i = 0; i < DATA_SIZE; i++) begin
                    data_out[i] <= out_from_store ? store[ptr][i] : data_in[i];
                end
                data_out_last <= (ptr == PTR_LAST);
            end
        end
    end

endmodule

// File: tb/tb_input_replay_buffer.sv
// tb/tb_input_replay_buffer.sv - scoreboard bench for input_replay_buffer
module tb_input_replay_buffer;

    localparam int DW    = 8;
    localparam int DS    = 4;
    localparam int DEPTH = 3;

    typedef struct packed {
        logic [31:0] d;
        logic        last;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0] in1 [DS];
    logic [DW-1:0] out1 [DS];
    logic          v1, r1, ov1, or1, ol1;
    logic [DW-1:0] in2 [DS];
    logic [DW-1:0] out2 [DS];
    logic          v2, r2, ov2, or2, ol2;

    input_replay_buffer #(.DATA_WIDTH(DW), .DATA_SIZE(DS), .DEPTH(DEPTH), .REPEAT(2)) dut (
        .clk(clk), .rst(rst),
        .data_in(in1), .data_in_valid(v1), .data_in_ready(r1),
        .data_out(out1), .data_out_valid(ov1), .data_out_ready(or1), .data_out_last(ol1)
    );

    input_replay_buffer #(.DATA_WIDTH(DW), .DATA_SIZE(DS), .DEPTH(DEPTH), .REPEAT(1)) dut_r1 (
        .clk(clk), .rst(rst),
        .data_in(in2), .data_in_valid(v2), .data_in_ready(r2),
        .data_out(out2), .data_out_valid(ov2), .data_out_ready(or2), .data_out_last(ol2)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pack(input logic [DW-1:0] a [DS]);
        logic [31:0] w;
        for (int i = 0; i < DS; i++) w[8*i +: 8] = a[i];
        return w;
    endfunction

    task automatic set1(input logic [31:0] w);
        for (int i = 0; i < DS; i++) in1[i] = w[8*i +: 8];
    endtask

    task automatic set2(input logic [31:0] w);
        for (int i = 0; i < DS; i++) in2[i] = w[8*i +: 8];
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    beat_t       q1[$];
    beat_t       q2[$];
    beat_t       e1, e2;
    logic [31:0] vec [DEPTH];
    int          idx1 = 0;
    int          idx2 = 0;
    int          in_cyc[$];
    int          out_cyc[$];
    logic        stall_prev = 1'b0;
    logic [31:0] stall_d;
    logic        stall_l;
    logic        p2_pend = 1'b0;
    logic [31:0] p2_d;
    int          n_out2 = 0;

    always @(negedge clk) begin
        if (!rst) begin
            q1.delete();
            q2.delete();
            idx1 = 0;
            idx2 = 0;
            stall_prev = 1'b0;
            p2_pend = 1'b0;
        end else begin
            if (stall_prev) begin
                check("hold_data", 64'(pack(out1)), 64'(stall_d));
                check("hold_last", 64'(ol1), 64'(stall_l));
                check("hold_valid", 64'(ov1), 64'd1);
            end
            stall_prev = ov1 && !or1;
            stall_d    = pack(out1);
            stall_l    = ol1;

            if (v1 && r1) begin
                vec[idx1] = pack(in1);
                q1.push_back(beat_t'{d: pack(in1), last: (idx1 == DEPTH - 1)});
                in_cyc.push_back(cyc);
                if (idx1 == DEPTH - 1) begin
                    for (int k = 0; k < DEPTH; k++)
                        q1.push_back(beat_t'{d: vec[k], last: (k == DEPTH - 1)});
                    idx1 = 0;
                end else begin
                    idx1++;
                end
            end
            if (ov1 && or1) begin
                if (q1.size() == 0) begin
                    check("out1_unexpected", 64'd1, 64'd0);
                end else begin
                    e1 = q1.pop_front();
                    check("out1_data", 64'(pack(out1)), 64'(e1.d));
                    check("out1_last", 64'(ol1), 64'(e1.last));
                end
                out_cyc.push_back(cyc);
            end

            check("ready2", 64'(r2), 64'(!ov2 || or2));
            if (p2_pend) begin
                check("lat2_valid", 64'(ov2), 64'd1);
                check("lat2_data", 64'(pack(out2)), 64'(p2_d));
            end
            p2_pend = v2 && r2;
            p2_d    = pack(in2);
            if (v2 && r2) begin
                q2.push_back(beat_t'{d: pack(in2), last: (idx2 == DEPTH - 1)});
                idx2 = (idx2 == DEPTH - 1) ? 0 : idx2 + 1;
            end
            if (ov2 && or2) begin
                n_out2++;
                if (q2.size() == 0) begin
                    check("out2_unexpected", 64'd1, 64'd0);
                end else begin
                    e2 = q2.pop_front();
                    check("out2_data", 64'(pack(out2)), 64'(e2.d));
                    check("out2_last", 64'(ol2), 64'(e2.last));
                end
            end
        end
    end

    task automatic send1(input logic [31:0] w);
        int   g = 0;
        logic acc;
        set1(w);
        v1 = 1'b1;
        do begin
            @(negedge clk);
            acc = r1;
            @(posedge clk);
            #1;
            g++;
        end while (!acc && g < 200);
        if (!acc) check("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain1();
        int g = 0;
        while (q1.size() != 0 && g < 100) begin
            @(posedge clk);
            #1;
            g++;
        end
        @(posedge clk);
        #1;
        check("drain1_empty", 64'(q1.size()), 64'd0);
    endtask

    task automatic check_gapless(input string tag, input int from, input int to);
        for (int k = from; k <= to; k++)
            check(tag, 64'(out_cyc[k] - out_cyc[k-1]), 64'd1);
    endtask

    localparam logic [31:0] A = 32'hA3A2A1A0;
    localparam logic [31:0] B = 32'hB3B2B1B0;
    localparam logic [31:0] C = 32'hC3C2C1C0;

    initial begin
        v1 = 1'b0; v2 = 1'b0; or1 = 1'b1; or2 = 1'b0;
        set1('0); set2('0);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 64'(ov1), 64'd0);
        check("rst_last", 64'(ol1), 64'd0);
        check("rst_data", 64'(pack(out1)), 64'd0);
        check("rst_ready", 64'(r1), 64'd1);
        check("rst_valid2", 64'(ov2), 64'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // back-to-back vector, continuous ready
        in_cyc.delete(); out_cyc.delete();
        send1(A); send1(B); send1(C);
        v1 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("replay_ready_low", 64'(r1), 64'd0);
        end
        @(negedge clk);
        check("ready_after_replay", 64'(r1), 64'd1);
        drain1();
        check("basic_count", 64'(out_cyc.size()), 64'd6);
        if (out_cyc.size() == 6 && in_cyc.size() == 3) begin
            check("basic_latency", 64'(out_cyc[0]), 64'(in_cyc[0] + 1));
            check_gapless("basic_gapless", 1, 5);
        end

        // stall during second-pass B
        out_cyc.delete();
        send1(A); send1(B); send1(C);
        v1 = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        or1 = 1'b0;
        check("stall_beat", 64'(pack(out1)), 64'(B));
        repeat (4) @(posedge clk);
        #1;
        or1 = 1'b1;
        drain1();
        check("stall_count", 64'(out_cyc.size()), 64'd6);

        // reset during second-pass A
        send1(A); send1(B); send1(C);
        v1 = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("midrst_valid", 64'(ov1), 64'd0);
        check("midrst_last", 64'(ol1), 64'd0);
        check("midrst_data", 64'(pack(out1)), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        out_cyc.delete();
        send1(32'hD3D2D1D0); send1(32'hE3E2E1E0); send1(32'hF3F2F1F0);
        v1 = 1'b0;
        drain1();
        check("postrst_count", 64'(out_cyc.size()), 64'd6);

        // two vectors streamed continuously
        in_cyc.delete(); out_cyc.delete();
        for (int k = 0; k < 6; k++) send1(32'h11111111 * (k + 1));
        v1 = 1'b0;
        drain1();
        check("stream_count", 64'(out_cyc.size()), 64'd12);
        if (out_cyc.size() == 12 && in_cyc.size() == 6) begin
            check_gapless("stream_gapless", 1, 11);
            check("next_vec_accept", 64'(in_cyc[3]), 64'(out_cyc[5]));
        end

        // valid toggling 1,0,1,0,1
        out_cyc.delete();
        send1(A); v1 = 1'b0; @(posedge clk); #1;
        send1(B); v1 = 1'b0; @(posedge clk); #1;
        send1(C); v1 = 1'b0;
        drain1();
        check("toggle_count", 64'(out_cyc.size()), 64'd6);
        if (out_cyc.size() == 6) begin
            check("fill_bubble_0", 64'(out_cyc[1] - out_cyc[0]), 64'd2);
            check("fill_bubble_1", 64'(out_cyc[2] - out_cyc[1]), 64'd2);
            check_gapless("replay_gapless", 3, 5);
        end

        // REPEAT=1 instance, random valid/ready
        begin
            int acc_n = 0;
            int g = 0;
            logic hold = 1'b0;
            while (acc_n < 50 && g < 3000) begin
                if (!hold) begin
                    v2 = 1'($urandom_range(0, 1));
                    set2($urandom);
                end
                or2 = 1'($urandom_range(0, 1));
                @(negedge clk);
                hold = v2 && !r2;
                if (v2 && r2) acc_n++;
                @(posedge clk);
                #1;
                g++;
            end
            v2 = 1'b0;
            or2 = 1'b1;
            check("r1_accepted", 64'(acc_n), 64'd50);
            g = 0;
            while (q2.size() != 0 && g < 100) begin
                @(posedge clk);
                #1;
                g++;
            end
            @(posedge clk);
            #1;
            check("r1_drain_empty", 64'(q2.size()), 64'd0);
            check("r1_out_count", 64'(n_out2), 64'd50);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach summary, got timeout expected finish");
        $fatal(1);
    end

endmodule
